// File: rtl/ctrl_pkg.sv
// Shared control definitions for the SCU multi-cycle controller.
// Holds the opcode map, FSM state encoding, alu_sel and pc_src encodings,
// and a helper that groups opcodes into the classes the FSM branches on.
// The datapath and the testbench import it as well.
package ctrl_pkg;

  // Opcodes, IR[31:28]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  // FSM state encoding
  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // alu_sel encoding
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_NEG    = 3'd2;
  localparam logic [2:0] ALU_PASS_B = 3'd3;

  // pc_src encoding
  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_RS   = 2'd1;
  localparam logic [1:0] PC_SRC_DMEM = 2'd2;

  // What DECODE does with an opcode: retire now, go through EXEC,
  // go through MEM, or trap.
  typedef enum logic [1:0] {
    CLS_BRANCH,
    CLS_ALU,
    CLS_MEM,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_NOP, OP_J, OP_BRZ, OP_BRN:               cls = CLS_BRANCH;
      OP_ADD, OP_SUB, OP_NEG, OP_INC, OP_SVPC:    cls = CLS_ALU;
      OP_LD, OP_ST, OP_JM:                        cls = CLS_MEM;
      default:                                    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Memory handshake watchdog.
// Counts cycles in which a request is outstanding without an ack and
// flags expiry on the TIMEOUT-th such cycle. An ack on that same cycle
// suppresses expiry. TIMEOUT = 0 disables the watchdog.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       restart the count (new wait phase begins next cycle)
//   req, ack  the handshake being watched
//   expired   combinational; high on the cycle the budget runs out
module ack_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (req && !ack && count_q != LAST) begin
      count_q <= count_q + CW'(1);
    end
  end

  // count_q holds the number of unanswered cycles already seen, so the
  // current cycle is the TIMEOUT-th when it equals TIMEOUT-1.
  assign expired = (TIMEOUT != 0) && req && !ack && (count_q == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the 32-bit SCU datapath.
// Sequences BOOT -> FETCH -> DECODE -> {EXEC -> WB | MEM [-> WB]} -> FETCH,
// with FAULT as a sticky trap for illegal opcodes and memory timeouts.
// All outputs are decoded from the current state and opcode (plus the acks
// for the handshake cycles) and are forced low while rst is high.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode, z_flag, n_flag   IR[31:28] and datapath flags
//   imem_req/imem_ack        instruction fetch handshake
//   dmem_req/dmem_we/ack     data memory handshake (we: 1 = store)
//   ir_we, pc_we, pc_src     IR load, PC update and PC source select
//   imm_gen, alu_*           immediate select and ALU operand/op controls
//   reg_we, wb_sel           register write-back enable and source
//   instr_done               retire pulse, coincides with pc_we
//   fault                    sticky trap indicator
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int ALUW    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            z_flag,
  input  logic            n_flag,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            imm_gen,
  output logic [ALUW-1:0] alu_sel,
  output logic            alu_a_pc,
  output logic            alu_src_imm,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            instr_done,
  output logic            fault
);

  logic [2:0]      state_q, state_d;
  op_class_e       cls;
  logic            wd_clr, wd_req, wd_ack, wd_expired;
  logic [ALUW-1:0] alu_sel_op;
  logic            alu_a_pc_op, alu_src_imm_op, imm_gen_op;
  logic [1:0]      branch_src;

  assign cls = op_class(opcode);

  // ALU setup implied by the opcode; applied in EXEC and held through WB
  // so the result stays stable while it is written back.
  // NOTE: every signal assigned in an always_comb gets a default first,
  // so no path through the case statements can infer a latch.
  always_comb begin
    alu_sel_op     = ALUW'(ALU_ADD);
    alu_a_pc_op    = 1'b0;
    alu_src_imm_op = 1'b0;
    imm_gen_op     = 1'b0;
    case (opcode)
      OP_SUB: alu_sel_op = ALUW'(ALU_SUB);
      OP_NEG: alu_sel_op = ALUW'(ALU_NEG);
      OP_INC: alu_src_imm_op = 1'b1;
      OP_SVPC: begin
        alu_a_pc_op    = 1'b1;
        alu_src_imm_op = 1'b1;
        imm_gen_op     = 1'b1;
      end
      default: ;
    endcase
  end

  // PC source for instructions that retire in DECODE.
  always_comb begin
    branch_src = PC_SRC_INC;
    case (opcode)
      OP_J:    branch_src = PC_SRC_RS;
      OP_BRZ:  branch_src = z_flag ? PC_SRC_RS : PC_SRC_INC;
      OP_BRN:  branch_src = n_flag ? PC_SRC_RS : PC_SRC_INC;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SRC_INC;
    imm_gen     = 1'b0;
    alu_sel     = '0;
    alu_a_pc    = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_BOOT: state_d = S_FETCH;

        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (wd_expired) begin
            state_d = S_FAULT;
          end
        end

        S_DECODE: begin
          case (cls)
            CLS_BRANCH: begin
              pc_we      = 1'b1;
              pc_src     = branch_src;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            CLS_ALU:  state_d = S_EXEC;
            CLS_MEM:  state_d = S_MEM;
            default:  state_d = S_FAULT;
          endcase
        end

        S_EXEC: begin
          alu_sel     = alu_sel_op;
          alu_a_pc    = alu_a_pc_op;
          alu_src_imm = alu_src_imm_op;
          imm_gen     = imm_gen_op;
          state_d     = S_WB;
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OP_ST);
          if (dmem_ack) begin
            if (opcode == OP_LD) begin
              state_d = S_WB;
            end else begin
              pc_we      = 1'b1;
              pc_src     = (opcode == OP_JM) ? PC_SRC_DMEM : PC_SRC_INC;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end else if (wd_expired) begin
            state_d = S_FAULT;
          end
        end

        S_WB: begin
          if (cls == CLS_ALU) begin
            alu_sel     = alu_sel_op;
            alu_a_pc    = alu_a_pc_op;
            alu_src_imm = alu_src_imm_op;
            imm_gen     = imm_gen_op;
          end
          reg_we     = 1'b1;
          wb_sel     = (opcode == OP_LD);
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_FAULT: fault = 1'b1;

        default: state_d = S_FAULT;
      endcase
    end
  end

  // The watchdog looks at whichever handshake the current state owns.
  // Any state change restarts it, so each FETCH/MEM wait starts at zero.
  assign wd_req = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign wd_ack = (state_q == S_FETCH) ? imem_ack : dmem_ack;
  assign wd_clr = (state_d != state_q);

  ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .req     (wd_req),
    .ack     (wd_ack),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
